// File: rtl/sccb_req_arbiter_pkg.sv
// Shared types and widths for the SCCB request arbiter.
// State encodings and bus widths used by the arbiter and its interface.
package sccb_pkg;

    localparam int SCCB_ADDR_W = 8;
    localparam int SCCB_DATA_W = 8;
    localparam int GRANT_W     = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        GAP
    } sccb_state_e;

endpackage

// File: rtl/sccb_req_arbiter_if.sv
// Write-master side of the SCCB arbiter: start/addr/data out, busy/done back.
// master = arbiter, slave = SCCB write engine.
interface sccb_req_arbiter_if;
    import sccb_pkg::*;

    logic                   sccb_start;
    logic [SCCB_ADDR_W-1:0] sccb_addr;
    logic [SCCB_DATA_W-1:0] sccb_data;
    logic                   sccb_busy;
    logic                   sccb_done;

    modport master (
        output sccb_start,
        output sccb_addr,
        output sccb_data,
        input  sccb_busy,
        input  sccb_done
    );

    modport slave (
        input  sccb_start,
        input  sccb_addr,
        input  sccb_data,
        output sccb_busy,
        output sccb_done
    );

endinterface

// File: rtl/sccb_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of pending at or after ptr.
// ptr must be below N; valid is low when nothing is pending.
module rr_pick
    import sccb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]       pending,
    input  logic [GRANT_W-1:0] ptr,
    output logic [GRANT_W-1:0] winner,
    output logic               valid
);

    logic [2*N-1:0] rot;

    // Rotating a doubled copy puts the search start at bit 0.
    assign rot = {pending, pending} >> ptr;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid  = 1'b1;
                winner = GRANT_W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/sccb_req_arbiter.sv
// Round-robin sharing of one SCCB write master among NUM_REQ requesters.
// Optional WAIT_DONE abort counter and sticky sccb_err: define SCCB_TIMEOUT_EN.
module sccb_req_arbiter
    import sccb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int GAP_CYCLES     = 250,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_start,
    input  logic [SCCB_ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [SCCB_DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_pending,
    output logic [NUM_REQ-1:0]             req_done,
    output logic [NUM_REQ-1:0]             req_drop,
    sccb_req_arbiter_if.master             sccb,
    output logic [GRANT_W-1:0]             grant_id,
    output logic                           sccb_err
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sccb_state_e state, state_nxt;

    logic [NUM_REQ-1:0]     pending;
    logic [NUM_REQ-1:0]     done_vec;
    logic [NUM_REQ-1:0]     accept;
    logic [NUM_REQ-1:0]     drop;
    logic [SCCB_ADDR_W-1:0] hold_addr [NUM_REQ];
    logic [SCCB_DATA_W-1:0] hold_data [NUM_REQ];
    logic [SCCB_ADDR_W-1:0] addr_sel, addr_q;
    logic [SCCB_DATA_W-1:0] data_sel, data_q;
    logic [GRANT_W-1:0]     ptr, pick;
    logic                   pick_valid;
    logic [GW-1:0]          gap_cnt;
    logic                   finish;
    logic                   timeout_hit;
    logic                   grant_now;

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .pending (pending),
        .ptr     (ptr),
        .winner  (pick),
        .valid   (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_valid && !sccb.sccb_busy) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                finish = sccb.sccb_done || timeout_hit;
                if (finish) begin
                    state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_now = (state == IDLE) && (state_nxt == ISSUE);

    always_comb begin
        done_vec = '0;
        addr_sel = '0;
        data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            done_vec[i] = finish && (grant_id == GRANT_W'(i));
            if (pick == GRANT_W'(i)) begin
                addr_sel = hold_addr[i];
                data_sel = hold_data[i];
            end
        end
    end

    // A completing slot frees up in the same cycle a new start may claim it.
    assign accept = req_start & ~(pending & ~done_vec);
    assign drop   = req_start & pending & ~done_vec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending  <= '0;
            req_done <= '0;
            req_drop <= '0;
            ptr      <= '0;
            grant_id <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            gap_cnt  <= '0;
        end else begin
            pending  <= (pending & ~done_vec) | accept;
            req_done <= done_vec;
            req_drop <= drop;
            if (grant_now) begin
                grant_id <= pick;
                addr_q   <= addr_sel;
                data_q   <= data_sel;
            end
            if (finish) begin
                ptr <= (grant_id == GRANT_W'(NUM_REQ - 1)) ?
                       '0 : grant_id + 1'b1;
            end
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst_n) begin
                hold_addr[i] <= '0;
                hold_data[i] <= '0;
            end else if (accept[i]) begin
                hold_addr[i] <= req_addr[SCCB_ADDR_W*i +: SCCB_ADDR_W];
                hold_data[i] <= req_data[SCCB_DATA_W*i +: SCCB_DATA_W];
            end
        end
    end

`ifdef SCCB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt;
    logic          err_q;

    assign timeout_hit = (state == WAIT_DONE) && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= (state == WAIT_DONE) ? to_cnt + 1'b1 : '0;
            // A done landing on the last count is a normal completion.
            if (timeout_hit && !sccb.sccb_done) begin
                err_q <= 1'b1;
            end
        end
    end

    assign sccb_err = err_q;
`else
    assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
    assign sccb_err    = 1'b0;
`endif

    assign req_pending     = pending;
    assign sccb.sccb_start = (state == ISSUE);
    assign sccb.sccb_addr  = addr_q;
    assign sccb.sccb_data  = data_q;

endmodule

// File: doc/sccb_req_arbiter.md
Name: sccb_req_arbiter

Overview:
- Shares the single SCCB write master between NUM_REQ configuration requesters. Typical requesters:
  - boot-time default register loader
  - keypad manual config
  - HDR exposure/gain sequencer
- Each requester gives a one-cycle start pulse with an 8-bit address and 8-bit data. The block latches the request and arbitrates round-robin.
- It issues one SCCB write at a time, waits for completion, returns a per-requester done pulse, then enforces an inter-transaction gap.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- GAP_CYCLES, 250, idle clk cycles after each completed write before the next issue (10 us at 25 MHz). 0 = no gap.
- TIMEOUT_CYCLES, 50000, max clk cycles spent in WAIT_DONE before abort. Used only with SCCB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (25 MHz)
- rst_n  in  1  reset, synchronous, active-low
- req_start  in  NUM_REQ  per-requester one-cycle write request pulse
- req_addr  in  8*NUM_REQ  register address; requester i uses bits [8i+7:8i]
- req_data  in  8*NUM_REQ  register data, same packing
- req_pending  out  NUM_REQ  request i latched and not yet completed
- req_done  out  NUM_REQ  one-cycle pulse when request i completes or aborts
- req_drop  out  NUM_REQ  one-cycle pulse when req_start[i] is rejected because request i is already pending
- sccb_start  out  1  one-cycle start pulse to the SCCB master
- sccb_addr  out  8  address to the SCCB master, held stable from the issue cycle until done
- sccb_data  out  8  data to the SCCB master, same hold rule
- sccb_busy  in  1  SCCB master is mid-transaction
- sccb_done  in  1  one-cycle pulse from the SCCB master on write completion
- grant_id  out  3  index of the current or last granted requester
- sccb_err  out  1  sticky: a transaction timed out

Behaviour:
- Reset (rst_n=0 at a clk edge), from any state including mid-transaction:
  - state = IDLE
  - all pending bits and holding registers cleared
  - req_done, req_drop, sccb_start = 0
  - sccb_addr = sccb_data = 0
  - grant_id = 0, round-robin pointer = 0, gap/timeout counters = 0, sccb_err = 0
- Capture:
  - On req_start[i] with pending[i]=0, latch req_addr/req_data slice i into hold_i and set pending[i] next cycle.
  - With pending[i]=1, the request is ignored and req_drop[i] pulses next cycle. hold_i is unchanged.
  - If req_start[i] coincides with the cycle req_done[i] is generated, the new request is accepted: clearing happens first, then setting.
  - All requesters capture in parallel; any number may start in the same cycle.
- Arbitration: round-robin. The search starts at the index after the last grant; after reset it starts at index 0. The winner is the first pending index in circular order.
- FSM:
  - IDLE: if any pending bit is set and sccb_busy=0, record the winner as grant_id, drive sccb_addr/sccb_data from hold[winner], go to ISSUE. If sccb_busy=1, stay.
  - ISSUE: sccb_start=1 for exactly this cycle, then go to WAIT_DONE.
  - WAIT_DONE: on sccb_done, pulse req_done[grant_id], clear pending[grant_id], advance the pointer, go to GAP (or IDLE if GAP_CYCLES=0). sccb_done in any other state is ignored.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- Latency: pending set at cycle t with the FSM in IDLE gives sccb_start at t+2 (grant at t+1, issue at t+2). With back-to-back requests, the next sccb_start comes GAP_CYCLES+2 cycles after sccb_done.
- sccb_addr/sccb_data change only on the IDLE->ISSUE transition.
- Fairness: a requester that re-requests immediately after its done cannot win again while another requester is pending.

Optional Feature:
- Macro: SCCB_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT_DONE. On reaching TIMEOUT_CYCLES-1 without sccb_done, the block pulses req_done[grant_id], clears pending[grant_id], sets sccb_err (sticky until reset), advances the pointer and goes to GAP.
  - If sccb_done arrives in the same cycle as the timeout, it is a normal completion and sccb_err is not set.
- Not defined: WAIT_DONE waits indefinitely, no counter is synthesised, and sccb_err is tied 0.

Decomposition:
- Package sccb_pkg:
  - FSM state encodings (IDLE, ISSUE, WAIT_DONE, GAP)
  - SCCB_ADDR_W=8, SCCB_DATA_W=8
  - GRANT_W=3
- Sub-module rr_pick, combinational: inputs pending vector and pointer; outputs winner index and valid. Reused later for other shared-resource arbiters.

Test Plan:
- Single request: req_start[1] with addr 0x12, data 0x80, idle master.
  - Required: sccb_start 2 cycles later with sccb_addr=0x12, sccb_data=0x80, grant_id=1.
  - Then sccb_done gives req_done[1] next cycle and pending[1]=0.
- Simultaneous: req_start=3'b111 with addrs 0x10/0x11/0x12 after reset.
  - Required: grant order 0,1,2.
  - sccb_start edges at least GAP_CYCLES+2 cycles apart after each done.
- Drop: req_start[2] twice while pending[2]=1.
  - Required: second pulse gives req_drop[2], and the original addr/data are written.
- Busy/ignore:
  - Hold sccb_busy=1 with pending[0] set: no sccb_start until busy falls.
  - A stray sccb_done in IDLE gives no req_done.
- Reset mid-WAIT_DONE: all outputs return to reset values, and pending requests are lost.
- Timeout (SCCB_TIMEOUT_EN, TIMEOUT_CYCLES=100): no sccb_done.
  - Required: req_done at cycle 100 of WAIT_DONE and sccb_err=1 until reset.
